// File: rtl/piso_serial_pkg.sv
// Shared types and helpers for the piso_serial_tx transmitter.
//   state_e   : transmitter state (idle or shifting a frame out)
//   STATE_W   : bit width of the state register
//   cnt_width : width of the bit counter for a given word width
package piso_serial_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam int STATE_W = 1;

  // The counter must hold WIDTH-1; never let it collapse to zero bits.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/dff_sync_rst.sv
// W-bit D register with synchronous active-low reset to zero.
//   clk  : rising-edge clock
//   rstn : synchronous reset, active low, sampled only at posedge clk
//   d    : next value
//   q    : registered value
module dff_sync_rst #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Storage flop: reset wins over the data input at the edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      q <= {W{1'b0}};
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/piso_serial_tx.sv
// Parallel-in/serial-out transmitter. A word accepted on the valid/ready
// handshake is shifted out one bit per clock, starting the cycle after the
// accepting edge; a new word may be accepted on the last bit of a frame so
// consecutive frames have no gap.
//   clk         : rising-edge clock
//   rstn        : synchronous active-low reset
//   load_valid  : load_data holds a word to send
//   load_ready  : a word can be accepted this cycle
//   load_data   : parallel word
//   ser_out     : serial bit (IDLE_LEVEL outside a frame)
//   ser_valid   : ser_out carries a frame bit
//   frame_start : pulse with the first bit of a frame
//   frame_done  : pulse with the last bit of a frame
module piso_serial_tx
  import piso_serial_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_done
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [STATE_W-1:0] state_bits_q;
  state_e             state_q;
  state_e             state_d;
  logic [WIDTH-1:0]   shreg_q;
  logic [WIDTH-1:0]   shreg_d;
  logic [CW-1:0]      cnt_q;
  logic [CW-1:0]      cnt_d;
  logic [WIDTH-1:0]   shifted_s;
  logic               accept_s;

  dff_sync_rst #(.W(STATE_W)) u_state_reg (
    .clk  (clk),
    .rstn (rstn),
    .d    (state_d),
    .q    (state_bits_q)
  );

  dff_sync_rst #(.W(WIDTH)) u_shreg_reg (
    .clk  (clk),
    .rstn (rstn),
    .d    (shreg_d),
    .q    (shreg_q)
  );

  dff_sync_rst #(.W(CW)) u_cnt_reg (
    .clk  (clk),
    .rstn (rstn),
    .d    (cnt_d),
    .q    (cnt_q)
  );

  assign state_q  = state_e'(state_bits_q);
  assign accept_s = load_valid && load_ready;

  // Move the register one place toward the output end, zero-filling behind.
  assign shifted_s = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                               : {1'b0, shreg_q[WIDTH-1:1]};

  // Next-state logic: load on accept, otherwise shift and count down.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_SHIFT;
          shreg_d = load_data;
          cnt_d   = CNT_LAST;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (accept_s) begin
          // Only possible on the last bit: reload for a gapless next frame.
          state_d = ST_SHIFT;
          shreg_d = load_data;
          cnt_d   = CNT_LAST;
        end else if (cnt_q == CNT_ZERO) begin
          state_d = ST_IDLE;
          shreg_d = shifted_s;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_SHIFT;
          shreg_d = shifted_s;
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        shreg_d = {WIDTH{1'b0}};
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Output decode: everything derives from registered state only.
  always_comb begin
    ser_valid   = 1'b0;
    ser_out     = IDLE_LEVEL;
    frame_start = 1'b0;
    frame_done  = 1'b0;
    load_ready  = 1'b1;
    if (state_q == ST_SHIFT) begin
      ser_valid   = 1'b1;
      ser_out     = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
      frame_start = (cnt_q == CNT_LAST);
      frame_done  = (cnt_q == CNT_ZERO);
      load_ready  = (cnt_q == CNT_ZERO);
    end else begin
      ser_valid   = 1'b0;
      ser_out     = IDLE_LEVEL;
      frame_start = 1'b0;
      frame_done  = 1'b0;
      load_ready  = 1'b1;
    end
  end

endmodule

// File: tb/tb_piso_serial_tx.sv
module tb_piso_serial_tx;

  localparam int W = 8;

  logic         clk;
  logic         rstn;
  logic         load_valid;
  logic [W-1:0] load_data;

  logic m_ready, m_out, m_valid, m_start, m_done;
  logic l_ready, l_out, l_valid, l_start, l_done;

  int n_vec;
  int n_err;

  // Reference model: bits still to send in the current frame and its word.
  int           rem;
  logic [W-1:0] word;

  piso_serial_tx #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_msb (
    .clk         (clk),
    .rstn        (rstn),
    .load_valid  (load_valid),
    .load_ready  (m_ready),
    .load_data   (load_data),
    .ser_out     (m_out),
    .ser_valid   (m_valid),
    .frame_start (m_start),
    .frame_done  (m_done)
  );

  piso_serial_tx #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
    .clk         (clk),
    .rstn        (rstn),
    .load_valid  (load_valid),
    .load_ready  (l_ready),
    .load_data   (load_data),
    .ser_out     (l_out),
    .ser_valid   (l_valid),
    .frame_start (l_start),
    .frame_done  (l_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Expected serial bit: p-th bit sent of the current word.
  function automatic logic exp_bit(input bit msb);
    int p;
    p = W - rem;
    if (rem == 0) return 1'b0;
    return msb ? word[W-1-p] : word[p];
  endfunction

  task automatic check_model();
    logic busy;
    busy = (rem > 0);
    cmp("msb.ser_valid",   m_valid, busy);
    cmp("msb.ser_out",     m_out,   exp_bit(1'b1));
    cmp("msb.frame_start", m_start, rem == W);
    cmp("msb.frame_done",  m_done,  rem == 1);
    cmp("msb.load_ready",  m_ready, rem <= 1);
    cmp("lsb.ser_valid",   l_valid, busy);
    cmp("lsb.ser_out",     l_out,   exp_bit(1'b0));
    cmp("lsb.frame_start", l_start, rem == W);
    cmp("lsb.frame_done",  l_done,  rem == 1);
    cmp("lsb.load_ready",  l_ready, rem <= 1);
  endtask

  // Apply inputs for one edge, advance the model, check after the edge.
  task automatic step(input logic r, input logic v, input logic [W-1:0] d);
    rstn       = r;
    load_valid = v;
    load_data  = d;
    @(posedge clk);
    if (!r) begin
      rem = 0;
    end else if (v && (rem <= 1)) begin
      word = d;
      rem  = W;
    end else if (rem > 0) begin
      rem--;
    end
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         e_out;
    logic         e_val;
    logic         e_start;
    logic         e_done;
    logic         e_ready;
  } vec_t;

  vec_t tbl[9];
  int   vcount;

  initial begin
    n_vec = 0;
    n_err = 0;
    rem   = 0;
    word  = '0;
    rstn       = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;

    // Single MSB-first frame of 8'hA5, expectations written out by hand.
    tbl[0] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset state, with load_valid asserted to show reset dominates.
    step(1'b0, 1'b1, 8'hFF);
    step(1'b0, 1'b0, 8'h00);
    cmp("reset.ser_valid", m_valid, 1'b0);
    cmp("reset.ser_out",   m_out,   1'b0);
    cmp("reset.ready",     m_ready, 1'b1);
    step(1'b1, 1'b0, 8'h00);

    for (int i = 0; i < 9; i++) begin
      step(1'b1, tbl[i].v, tbl[i].d);
      cmp("tbl.ser_out",     m_out,   tbl[i].e_out);
      cmp("tbl.ser_valid",   m_valid, tbl[i].e_val);
      cmp("tbl.frame_start", m_start, tbl[i].e_start);
      cmp("tbl.frame_done",  m_done,  tbl[i].e_done);
      cmp("tbl.load_ready",  m_ready, tbl[i].e_ready);
    end

    // Back-to-back frames with load_valid held high.
    vcount = 0;
    step(1'b1, 1'b1, 8'hA5);
    vcount += int'(m_valid);
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b1, 8'h3C);
      vcount += int'(m_valid);
    end
    cmp("b2b.second_start", m_start, 1'b1);
    cmp("b2b.second_bit0",  m_out,   1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 8'h00);
      vcount += int'(m_valid);
    end
    n_vec++;
    if (vcount != 2 * W) begin
      n_err++;
      $display("FAIL b2b.valid_cycles: got %0d expected %0d", vcount, 2 * W);
    end

    // LSB-first 8'h01: a single 1 followed by seven 0s.
    step(1'b1, 1'b1, 8'h01);
    cmp("lsb01.first", l_out, 1'b1);
    for (int i = 1; i < W; i++) begin
      step(1'b1, 1'b0, 8'h00);
      cmp("lsb01.zero", l_out, 1'b0);
    end
    cmp("lsb01.done", l_done, 1'b1);
    step(1'b1, 1'b0, 8'h00);

    // Load attempt during the 3rd bit of an all-zero frame is ignored.
    step(1'b1, 1'b1, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    load_valid = 1'b1;
    load_data  = 8'hFF;
    #1;
    cmp("hs.ready_low", m_ready, 1'b0);
    step(1'b1, 1'b1, 8'hFF);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 8'h00);
      cmp("hs.no_capture", m_out, 1'b0);
    end

    // Reset in the middle of a frame aborts it without frame_done.
    step(1'b1, 1'b1, 8'hA5);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    cmp("abort.ser_valid",  m_valid, 1'b0);
    cmp("abort.ready",      m_ready, 1'b1);
    cmp("abort.ser_out",    m_out,   1'b0);
    cmp("abort.frame_done", m_done,  1'b0);
    step(1'b1, 1'b0, 8'h00);

    // A reset glitch between edges has no effect on a running frame.
    step(1'b1, 1'b1, 8'hA5);
    #1 rstn = 1'b0;
    #2 rstn = 1'b1;
    for (int i = 1; i < W; i++) step(1'b1, 1'b0, 8'h00);
    cmp("glitch.frame_done", m_done, 1'b1);
    cmp("glitch.last_bit",   m_out,  1'b1);
    step(1'b1, 1'b0, 8'h00);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 63) == 0) ? 1'b0 : 1'b1,
           1'($urandom_range(0, 1)),
           8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
